// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one AXI-lite cache port between fetch (read-only) and data (r/w).
// Optional grant counters (stat_i_cnt, stat_d_cnt) are built when ARB_STATS_EN is defined.
module cache_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   i_araddr,
   input  logic                i_arvalid,
   output logic                i_arready,
   output logic [DATA_W-1:0]   i_rdata,
   output logic [1:0]          i_rresp,
   output logic                i_rvalid,
   input  logic                i_rready,
   input  logic [ADDR_W-1:0]   d_araddr,
   input  logic                d_arvalid,
   output logic                d_arready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic [1:0]          d_rresp,
   output logic                d_rvalid,
   input  logic                d_rready,
   input  logic [ADDR_W-1:0]   d_awaddr,
   input  logic                d_awvalid,
   output logic                d_awready,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   input  logic                d_wvalid,
   output logic                d_wready,
   output logic [1:0]          d_bresp,
   output logic                d_bvalid,
   input  logic                d_bready,
   output logic [ADDR_W-1:0]   c_araddr,
   output logic                c_arvalid,
   input  logic                c_arready,
   input  logic [DATA_W-1:0]   c_rdata,
   input  logic [1:0]          c_rresp,
   input  logic                c_rvalid,
   output logic                c_rready,
   output logic [ADDR_W-1:0]   c_awaddr,
   output logic                c_awvalid,
   input  logic                c_awready,
   output logic [DATA_W-1:0]   c_wdata,
   output logic [DATA_W/8-1:0] c_wstrb,
   output logic                c_wvalid,
   input  logic                c_wready,
   input  logic [1:0]          c_bresp,
   input  logic                c_bvalid,
   output logic                c_bready
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]         stat_i_cnt,
   output logic [31:0]         stat_d_cnt
`endif
);

   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CA   = 3'd1;
   localparam logic [2:0] CR   = 3'd2;
   localparam logic [2:0] UR   = 3'd3;
   localparam logic [2:0] CW   = 3'd4;
   localparam logic [2:0] CB   = 3'd5;
   localparam logic [2:0] UB   = 3'd6;

   logic [2:0]        state_q, state_d;
   logic              rr_q, rr_d;        // 1: data port has priority on the next contested grant
   logic              owner_q, owner_d;  // 1: current read belongs to the data port

   logic              i_arready_q, i_arready_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [1:0]        i_rresp_q, i_rresp_d;
   logic              i_rvalid_q, i_rvalid_d;

   logic              d_arready_q, d_arready_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [1:0]        d_rresp_q, d_rresp_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic              d_wr_ready_q, d_wr_ready_d;
   logic [1:0]        d_bresp_q, d_bresp_d;
   logic              d_bvalid_q, d_bvalid_d;

   logic [ADDR_W-1:0] c_araddr_q, c_araddr_d;
   logic              c_arvalid_q, c_arvalid_d;
   logic              c_rready_q, c_rready_d;
   logic [ADDR_W-1:0] c_awaddr_q, c_awaddr_d;
   logic              c_awvalid_q, c_awvalid_d;
   logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
   logic [STRB_W-1:0] c_wstrb_q, c_wstrb_d;
   logic              c_wvalid_q, c_wvalid_d;
   logic              c_bready_q, c_bready_d;

   logic              req_i, req_dw, req_dr, req_d, pick_i;

   always_comb begin
      req_i  = i_arvalid;
      req_dw = d_awvalid & d_wvalid;
      req_dr = d_arvalid;
      req_d  = req_dw | req_dr;
      pick_i = req_i & (~req_d | ~rr_q);

      state_d      = state_q;
      rr_d         = rr_q;
      owner_d      = owner_q;
      i_arready_d  = 1'b0;
      d_arready_d  = 1'b0;
      d_wr_ready_d = 1'b0;
      i_rdata_d    = i_rdata_q;
      i_rresp_d    = i_rresp_q;
      i_rvalid_d   = i_rvalid_q;
      d_rdata_d    = d_rdata_q;
      d_rresp_d    = d_rresp_q;
      d_rvalid_d   = d_rvalid_q;
      d_bresp_d    = d_bresp_q;
      d_bvalid_d   = d_bvalid_q;
      c_araddr_d   = c_araddr_q;
      c_arvalid_d  = c_arvalid_q;
      c_rready_d   = c_rready_q;
      c_awaddr_d   = c_awaddr_q;
      c_awvalid_d  = c_awvalid_q;
      c_wdata_d    = c_wdata_q;
      c_wstrb_d    = c_wstrb_q;
      c_wvalid_d   = c_wvalid_q;
      c_bready_d   = c_bready_q;

      case (state_q)
         IDLE: begin
            if (pick_i) begin
               i_arready_d = 1'b1;
               c_araddr_d  = i_araddr;
               c_arvalid_d = 1'b1;
               owner_d     = 1'b0;
               rr_d        = 1'b1;
               state_d     = CA;
            end else if (req_dw) begin
               d_wr_ready_d = 1'b1;
               c_awaddr_d   = d_awaddr;
               c_wdata_d    = d_wdata;
               c_wstrb_d    = d_wstrb;
               c_awvalid_d  = 1'b1;
               c_wvalid_d   = 1'b1;
               rr_d         = 1'b0;
               state_d      = CW;
            end else if (req_dr) begin
               d_arready_d = 1'b1;
               c_araddr_d  = d_araddr;
               c_arvalid_d = 1'b1;
               owner_d     = 1'b1;
               rr_d        = 1'b0;
               state_d     = CA;
            end
         end
         CA: begin
            if (c_arready) begin
               c_arvalid_d = 1'b0;
               c_rready_d  = 1'b1;
               state_d     = CR;
            end
         end
         CR: begin
            if (c_rvalid) begin
               c_rready_d = 1'b0;
               if (owner_q) begin
                  d_rdata_d  = c_rdata;
                  d_rresp_d  = c_rresp;
                  d_rvalid_d = 1'b1;
               end else begin
                  i_rdata_d  = c_rdata;
                  i_rresp_d  = c_rresp;
                  i_rvalid_d = 1'b1;
               end
               state_d = UR;
            end
         end
         UR: begin
            if (owner_q && d_rready) begin
               d_rvalid_d = 1'b0;
               state_d    = IDLE;
            end else if (!owner_q && i_rready) begin
               i_rvalid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         CW: begin
            // Address and data handshakes complete independently, in any order.
            c_awvalid_d = c_awvalid_q & ~c_awready;
            c_wvalid_d  = c_wvalid_q & ~c_wready;
            if (!c_awvalid_d && !c_wvalid_d) begin
               c_bready_d = 1'b1;
               state_d    = CB;
            end
         end
         CB: begin
            if (c_bvalid) begin
               c_bready_d = 1'b0;
               d_bresp_d  = c_bresp;
               d_bvalid_d = 1'b1;
               state_d    = UB;
            end
         end
         UB: begin
            if (d_bready) begin
               d_bvalid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         owner_q      <= 1'b0;
         i_arready_q  <= 1'b0;
         i_rdata_q    <= '0;
         i_rresp_q    <= '0;
         i_rvalid_q   <= 1'b0;
         d_arready_q  <= 1'b0;
         d_rdata_q    <= '0;
         d_rresp_q    <= '0;
         d_rvalid_q   <= 1'b0;
         d_wr_ready_q <= 1'b0;
         d_bresp_q    <= '0;
         d_bvalid_q   <= 1'b0;
         c_araddr_q   <= '0;
         c_arvalid_q  <= 1'b0;
         c_rready_q   <= 1'b0;
         c_awaddr_q   <= '0;
         c_awvalid_q  <= 1'b0;
         c_wdata_q    <= '0;
         c_wstrb_q    <= '0;
         c_wvalid_q   <= 1'b0;
         c_bready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         owner_q      <= owner_d;
         i_arready_q  <= i_arready_d;
         i_rdata_q    <= i_rdata_d;
         i_rresp_q    <= i_rresp_d;
         i_rvalid_q   <= i_rvalid_d;
         d_arready_q  <= d_arready_d;
         d_rdata_q    <= d_rdata_d;
         d_rresp_q    <= d_rresp_d;
         d_rvalid_q   <= d_rvalid_d;
         d_wr_ready_q <= d_wr_ready_d;
         d_bresp_q    <= d_bresp_d;
         d_bvalid_q   <= d_bvalid_d;
         c_araddr_q   <= c_araddr_d;
         c_arvalid_q  <= c_arvalid_d;
         c_rready_q   <= c_rready_d;
         c_awaddr_q   <= c_awaddr_d;
         c_awvalid_q  <= c_awvalid_d;
         c_wdata_q    <= c_wdata_d;
         c_wstrb_q    <= c_wstrb_d;
         c_wvalid_q   <= c_wvalid_d;
         c_bready_q   <= c_bready_d;
      end
   end

   assign i_arready = i_arready_q;
   assign i_rdata   = i_rdata_q;
   assign i_rresp   = i_rresp_q;
   assign i_rvalid  = i_rvalid_q;
   assign d_arready = d_arready_q;
   assign d_rdata   = d_rdata_q;
   assign d_rresp   = d_rresp_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_awready = d_wr_ready_q;
   assign d_wready  = d_wr_ready_q;
   assign d_bresp   = d_bresp_q;
   assign d_bvalid  = d_bvalid_q;
   assign c_araddr  = c_araddr_q;
   assign c_arvalid = c_arvalid_q;
   assign c_rready  = c_rready_q;
   assign c_awaddr  = c_awaddr_q;
   assign c_awvalid = c_awvalid_q;
   assign c_wdata   = c_wdata_q;
   assign c_wstrb   = c_wstrb_q;
   assign c_wvalid  = c_wvalid_q;
   assign c_bready  = c_bready_q;

`ifdef ARB_STATS_EN
   logic [31:0] stat_i_q, stat_d_q;
   logic        grant_any, grant_i, grant_d;

   always_comb begin
      grant_any = (state_q == IDLE) && (state_d != IDLE);
      grant_i   = grant_any && (state_d == CA) && !owner_d;
      grant_d   = grant_any && !grant_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_i_q <= '0;
         stat_d_q <= '0;
      end else begin
         if (grant_i && (stat_i_q != 32'hFFFF_FFFF)) stat_i_q <= stat_i_q + 32'd1;
         if (grant_d && (stat_d_q != 32'hFFFF_FFFF)) stat_d_q <= stat_d_q + 32'd1;
      end
   end

   assign stat_i_cnt = stat_i_q;
   assign stat_d_cnt = stat_d_q;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter; also checks grant counters when ARB_STATS_EN is defined.
module tb_cache_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] i_araddr = '0;
   logic        i_arvalid = 1'b0, i_rready = 1'b0;
   logic        i_arready, i_rvalid;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic [31:0] d_araddr = '0, d_awaddr = '0, d_wdata = '0;
   logic [3:0]  d_wstrb = '0;
   logic        d_arvalid = 1'b0, d_rready = 1'b0, d_awvalid = 1'b0, d_wvalid = 1'b0;
   logic        d_bready = 1'b0;
   logic        d_arready, d_rvalid, d_awready, d_wready, d_bvalid;
   logic [31:0] d_rdata;
   logic [1:0]  d_rresp, d_bresp;
   logic [31:0] c_araddr, c_awaddr, c_wdata;
   logic [3:0]  c_wstrb;
   logic        c_arvalid, c_rready, c_awvalid, c_wvalid, c_bready;
   logic        c_arready = 1'b0, c_rvalid = 1'b0, c_awready = 1'b0, c_wready = 1'b0;
   logic        c_bvalid = 1'b0;
   logic [31:0] c_rdata = '0;
   logic [1:0]  c_rresp = '0, c_bresp = '0;
`ifdef ARB_STATS_EN
   logic [31:0] stat_i_cnt, stat_d_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cache_arbiter dut (
      .clk(clk), .rstn(rstn),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rready(i_rready),
      .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
      .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rready(d_rready),
      .d_awaddr(d_awaddr), .d_awvalid(d_awvalid), .d_awready(d_awready),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_bresp(d_bresp), .d_bvalid(d_bvalid), .d_bready(d_bready),
      .c_araddr(c_araddr), .c_arvalid(c_arvalid), .c_arready(c_arready),
      .c_rdata(c_rdata), .c_rresp(c_rresp), .c_rvalid(c_rvalid), .c_rready(c_rready),
      .c_awaddr(c_awaddr), .c_awvalid(c_awvalid), .c_awready(c_awready),
      .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_wvalid(c_wvalid), .c_wready(c_wready),
      .c_bresp(c_bresp), .c_bvalid(c_bvalid), .c_bready(c_bready)
`ifdef ARB_STATS_EN
      ,
      .stat_i_cnt(stat_i_cnt), .stat_d_cnt(stat_d_cnt)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // who: 0 fetch read, 1 data read, 2 data write, -1 no grant within budget
   task automatic wait_grant(output int who);
      who = -1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (i_arready) begin who = 0; break; end
         if (d_arready) begin who = 1; break; end
         if (d_awready) begin who = 2; break; end
      end
   endtask

   task automatic wait_rvalid(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if ((is_d ? d_rvalid : i_rvalid) == 1'b1) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   function automatic logic any_out();
      return |{i_arready, i_rdata, i_rresp, i_rvalid, d_arready, d_rdata, d_rresp, d_rvalid,
               d_awready, d_wready, d_bresp, d_bvalid, c_araddr, c_arvalid, c_rready,
               c_awaddr, c_awvalid, c_wdata, c_wstrb, c_wvalid, c_bready};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int who;
      bit ok;
      int exp_who;

      tick();
      tick();
      check_eq("rst outputs zero", 64'(any_out()), 64'd0);
      check_eq("rst c_arvalid", 64'(c_arvalid), 64'd0);
      check_eq("rst c_rready", 64'(c_rready), 64'd0);
      rstn = 1'b1;
      tick();

      // Fetch read with slow cache and slow consumer
      i_araddr  = 32'h0000_1000;
      i_arvalid = 1'b1;
      tick();
      check_eq("t1 i_arready pulse", 64'(i_arready), 64'd1);
      check_eq("t1 c_arvalid grant cycle", 64'(c_arvalid), 64'd1);
      check_eq("t1 c_araddr", 64'(c_araddr), 64'h1000);
      tick();
      i_arvalid = 1'b0;
      check_eq("t1 i_arready single", 64'(i_arready), 64'd0);
      check_eq("t1 c_arvalid held", 64'(c_arvalid), 64'd1);
      tick();
      check_eq("t1 c_araddr held", 64'(c_araddr), 64'h1000);
      c_arready = 1'b1;
      tick();
      c_arready = 1'b0;
      check_eq("t1 c_arvalid cleared", 64'(c_arvalid), 64'd0);
      check_eq("t1 c_rready set", 64'(c_rready), 64'd1);
      for (int k = 0; k < 5; k++) tick();
      check_eq("t1 i_rvalid early", 64'(i_rvalid), 64'd0);
      c_rvalid = 1'b1;
      c_rdata  = 32'hDEAD_BEEF;
      tick();
      c_rvalid = 1'b0;
      c_rdata  = 32'h0;
      check_eq("t1 c_rready cleared", 64'(c_rready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         check_eq("t1 i_rvalid held", 64'(i_rvalid), 64'd1);
         check_eq("t1 i_rdata held", 64'(i_rdata), 64'hDEAD_BEEF);
         tick();
      end
      i_rready = 1'b1;
      tick();
      i_rready = 1'b0;
      check_eq("t1 i_rvalid cleared", 64'(i_rvalid), 64'd0);

      // Data write with W handshake two cycles ahead of AW
      d_awaddr  = 32'h0000_2004;
      d_wdata   = 32'h1234_5678;
      d_wstrb   = 4'b0011;
      d_awvalid = 1'b1;
      d_wvalid  = 1'b1;
      wait_grant(who);
      check_eq("t2 write grant", 64'(who), 64'd2);
      check_eq("t2 d_wready", 64'(d_wready), 64'd1);
      check_eq("t2 c_awvalid", 64'(c_awvalid), 64'd1);
      check_eq("t2 c_awaddr", 64'(c_awaddr), 64'h2004);
      check_eq("t2 c_wdata", 64'(c_wdata), 64'h1234_5678);
      check_eq("t2 c_wstrb", 64'(c_wstrb), 64'h3);
      tick();
      d_awvalid = 1'b0;
      d_wvalid  = 1'b0;
      c_wready  = 1'b1;
      tick();
      c_wready = 1'b0;
      check_eq("t2 c_wvalid cleared", 64'(c_wvalid), 64'd0);
      check_eq("t2 c_awvalid still", 64'(c_awvalid), 64'd1);
      check_eq("t2 c_bready early", 64'(c_bready), 64'd0);
      tick();
      check_eq("t2 c_bready wait aw", 64'(c_bready), 64'd0);
      c_awready = 1'b1;
      tick();
      c_awready = 1'b0;
      check_eq("t2 c_awvalid cleared", 64'(c_awvalid), 64'd0);
      check_eq("t2 c_bready set", 64'(c_bready), 64'd1);
      c_bvalid = 1'b1;
      c_bresp  = 2'b00;
      tick();
      c_bvalid = 1'b0;
      check_eq("t2 d_bvalid", 64'(d_bvalid), 64'd1);
      check_eq("t2 d_bresp", 64'(d_bresp), 64'd0);
      check_eq("t2 c_bready cleared", 64'(c_bready), 64'd0);
      d_bready = 1'b1;
      tick();
      d_bready = 1'b0;
      check_eq("t2 d_bvalid cleared", 64'(d_bvalid), 64'd0);

      // Reset, then continuous fetch + data reads alternate starting with fetch
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      c_arready = 1'b1;
      c_rvalid  = 1'b1;
      c_rdata   = 32'hCAFE_0001;
      c_rresp   = 2'b00;
      i_rready  = 1'b1;
      d_rready  = 1'b1;
      d_araddr  = 32'h0000_3000;
      i_arvalid = 1'b1;
      d_arvalid = 1'b1;
      for (int n = 0; n < 6; n++) begin
         exp_who = n % 2;
         wait_grant(who);
         check_eq($sformatf("t3 grant %0d", n), 64'(who), 64'(exp_who));
      end
      tick();
      i_arvalid = 1'b0;
      d_arvalid = 1'b0;
      for (int k = 0; k < 5; k++) tick();

      // Data read and write together: write first, read on the next data grant
      c_awready = 1'b1;
      c_wready  = 1'b1;
      c_bvalid  = 1'b1;
      d_bready  = 1'b1;
      d_arvalid = 1'b1;
      d_awvalid = 1'b1;
      d_wvalid  = 1'b1;
      wait_grant(who);
      check_eq("t4 write first", 64'(who), 64'd2);
      check_eq("t4 d_arready during write", 64'(d_arready), 64'd0);
      tick();
      d_awvalid = 1'b0;
      d_wvalid  = 1'b0;
      check_eq("t4 d_arready after write grant", 64'(d_arready), 64'd0);
      wait_grant(who);
      check_eq("t4 read second", 64'(who), 64'd1);
      tick();
      d_arvalid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      c_awready = 1'b0;
      c_wready  = 1'b0;
      c_bvalid  = 1'b0;
      d_bready  = 1'b0;

      // Error response passes through unchanged, then the next request is served
      c_rresp   = 2'b10;
      c_rdata   = 32'h55AA_55AA;
      i_arvalid = 1'b1;
      wait_grant(who);
      check_eq("t5 fetch grant", 64'(who), 64'd0);
      tick();
      i_arvalid = 1'b0;
      wait_rvalid(1'b0, ok);
      check_eq("t5 i_rvalid seen", 64'(ok), 64'd1);
      check_eq("t5 i_rresp", 64'(i_rresp), 64'h2);
      check_eq("t5 i_rdata", 64'(i_rdata), 64'h55AA_55AA);
      c_rresp   = 2'b00;
      c_rdata   = 32'h1357_9BDF;
      d_arvalid = 1'b1;
      wait_grant(who);
      check_eq("t5 next grant", 64'(who), 64'd1);
      tick();
      d_arvalid = 1'b0;
      wait_rvalid(1'b1, ok);
      check_eq("t5 d_rvalid seen", 64'(ok), 64'd1);
      check_eq("t5 d_rresp", 64'(d_rresp), 64'h0);
      check_eq("t5 d_rdata", 64'(d_rdata), 64'h1357_9BDF);
      for (int k = 0; k < 3; k++) tick();

      // Asynchronous reset while waiting in CR
      c_rvalid  = 1'b0;
      i_araddr  = 32'h0000_4440;
      i_arvalid = 1'b1;
      wait_grant(who);
      check_eq("t6 fetch grant", 64'(who), 64'd0);
      tick();
      i_arvalid = 1'b0;
      check_eq("t6 in CR c_rready", 64'(c_rready), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_eq("t6 async rst outputs zero", 64'(any_out()), 64'd0);
`ifdef ARB_STATS_EN
      check_eq("t6 stat_i after rst", 64'(stat_i_cnt), 64'd0);
      check_eq("t6 stat_d after rst", 64'(stat_d_cnt), 64'd0);
`endif
      tick();
      tick();
      rstn = 1'b1;
      tick();
      c_rvalid  = 1'b1;
      c_rdata   = 32'h0BAD_F00D;
      i_araddr  = 32'h0000_5000;
      i_arvalid = 1'b1;
      wait_grant(who);
      check_eq("t6 post-rst grant", 64'(who), 64'd0);
      check_eq("t6 post-rst c_araddr", 64'(c_araddr), 64'h5000);
      tick();
      i_arvalid = 1'b0;
      wait_rvalid(1'b0, ok);
      check_eq("t6 post-rst i_rvalid", 64'(ok), 64'd1);
      check_eq("t6 post-rst i_rdata", 64'(i_rdata), 64'h0BAD_F00D);
`ifdef ARB_STATS_EN
      check_eq("t6 stat_i after fetch", 64'(stat_i_cnt), 64'd1);
      check_eq("t6 stat_d after fetch", 64'(stat_d_cnt), 64'd0);
`endif
      tick();
      c_rvalid = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single MMU-side AXI-lite slave port of the L2 data cache between the instruction-fetch requester (read-only) and the data requester (read/write).
- Accepts one upstream transaction and forwards it to the cache. It waits for the cache response, returns it to the owner, and only then accepts the next transaction. There is never more than one transaction outstanding.
- Arbitration is round-robin between the two requesters.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
i_araddr  in  ADDR_W  fetch read address
i_arvalid  in  1  fetch read request
i_arready  out  1  fetch address accepted
i_rdata  out  DATA_W  fetch read data
i_rresp  out  2  fetch read response
i_rvalid  out  1  fetch read data valid
i_rready  in  1  fetch read data taken
d_araddr/d_arvalid/d_arready  in/in/out  ADDR_W/1/1  data read address channel
d_rdata/d_rresp/d_rvalid/d_rready  out/out/out/in  DATA_W/2/1/1  data read channel
d_awaddr/d_awvalid/d_awready  in/in/out  ADDR_W/1/1  data write address channel
d_wdata/d_wstrb/d_wvalid/d_wready  in/in/in/out  DATA_W/DATA_W/8/1/1  data write channel
d_bresp/d_bvalid/d_bready  out/out/in  2/1/1  data write response
c_araddr, c_arvalid, c_arready  out, out, in  ADDR_W, 1, 1  cache read address
c_rdata, c_rresp, c_rvalid, c_rready  in, in, in, out  DATA_W, 2, 1, 1  cache read data
c_awaddr, c_awvalid, c_awready  out, out, in  ADDR_W, 1, 1  cache write address
c_wdata, c_wstrb, c_wvalid, c_wready  out, out, out, in  DATA_W, DATA_W/8, 1, 1  cache write data
c_bresp, c_bvalid, c_bready  in, in, out  2, 1, 1  cache write response

Behaviour:
- Reset (rstn low, asynchronous):
  - State is IDLE.
  - All valid and ready outputs are 0.
  - All data, address and resp outputs are 0.
  - The round-robin pointer selects fetch first.
- A reset asserted mid-transaction abandons the transaction. The requesters must also be reset.
- All outputs are registered.

States:
- IDLE:
  - Request sources are fetch (i_arvalid), data read (d_arvalid) and data write (d_awvalid & d_wvalid).
  - Within the data port, a write wins over a read.
  - When both ports request, the port not served last wins, then the pointer flips. With a single requester, that requester wins.
  - On a grant, the arbiter pulses the winner's ready for exactly 1 cycle: i_arready, d_arready, or d_awready and d_wready together.
  - In the same cycle it captures the address, data and strb, and drives the c_ valid outputs (c_arvalid, or c_awvalid with c_wvalid). It then moves to CA or CW.
- CA: holds c_arvalid and c_araddr until c_arready is sampled high, then clears c_arvalid, sets c_rready=1 and moves to CR.
- CR: on c_rvalid, clears c_rready, registers c_rdata and c_rresp, and asserts the owner's rvalid. Moves to UR.
- UR: holds rvalid, rdata and rresp stable until the owner's rready is high. Then clears rvalid and returns to IDLE.
- CW:
  - Clears c_awvalid and c_wvalid independently as c_awready and c_wready are seen; the two may arrive in any order or the same cycle.
  - When both have cleared, sets c_bready=1 and moves to CB.
- CB: on c_bvalid, clears c_bready, registers c_bresp, asserts d_bvalid and moves to UB.
- UB: holds d_bvalid until d_bready, then returns to IDLE.

Timing and error handling:
- Minimum turnaround is 1 cycle of IDLE between transactions. Grant-to-cache-valid latency is 0 extra cycles, because the c_ valid outputs are driven in the grant cycle.
- rresp and bresp pass through unmodified. An error response, including resp[1]=1, is not special-cased.
- Requests arriving while not in IDLE are left pending; the requester keeps valid high.

Optional Feature:
- Macro: ARB_STATS_EN
- With the macro defined:
  - Adds output ports stat_i_cnt (32 bits, out) and stat_d_cnt (32 bits, out).
  - Each counter increments on every grant to its port and saturates at 0xFFFFFFFF.
  - Both are cleared by rstn.
- Without the macro: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Fetch read 0x00001000, cache returns 0xDEADBEEF after 5 cycles:
  - i_arready pulses once, and c_araddr=0x00001000 is held until c_arready.
  - i_rdata=0xDEADBEEF with i_rvalid held while i_rready=0 for 3 cycles.
- Data write 0x00002004, data 0x12345678, strb 4'b0011; c_wready arrives 2 cycles before c_awready:
  - c_wdata and c_wstrb are correct.
  - c_bready rises only after both handshakes.
  - d_bvalid is asserted and d_bresp=0.
- Fetch and data reads held continuously for 6 transactions: grants alternate i, d, i, d, i, d, starting with fetch after reset.
- Data read and data write asserted together: the write is granted first and the read on the next data grant. d_arready stays 0 during the write.
- Cache returns rresp=2'b10: the owner sees i_rresp=2'b10 and the arbiter returns to IDLE and serves the next request.
- rstn pulled low while in CR: all outputs are 0 immediately without a clock edge. After release, a new fetch completes normally. With ARB_STATS_EN defined, the counters read 0 after reset and 1 after the new fetch.
